sensor_guard_multi: RTL and testbench

SENSOR_GUARD_MULTI -- requirements
Module: sensor_guard_multi

---
 rtl/sensor_guard_multi.sv | 177 +++++++++++++++++
 tb/tb_sensor_guard_multi.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_guard_multi.sv
// Multi-channel sensor plausibility guard: per-channel warm-up, debounced trip,
// timed relay opening with bounded rechecks and a latched definitive failure.
module sensor_guard_multi #(
  parameter int N_CH       = 4,
  parameter int SEN_W      = 12,
  parameter int HEAT_TICKS = 125,
  parameter int DEBOUNCE   = 3,
  parameter int WAIT_TICKS = 313,
  parameter int MAX_RETRY  = 3
) (
  input  logic                    clk_16ms,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_CH*SEN_W-1:0]   sen,
  input  logic [N_CH*SEN_W-1:0]   sen_ref,
  input  logic [N_CH*SEN_W-1:0]   threshold,
  input  logic [N_CH-1:0]         clear_fail,
  output logic [N_CH-1:0]         relay_out,
  output logic [N_CH-1:0]         def_fail,
  output logic                    any_fail,
  output logic [3*N_CH-1:0]       state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEAT     = 3'd1,
    ST_MONITOR  = 3'd2,
    ST_OPEN     = 3'd3,
    ST_WAIT     = 3'd4,
    ST_RECHECK  = 3'd5,
    ST_DEF_FAIL = 3'd6
  } state_t;

  localparam int HW = $clog2(HEAT_TICKS) + 1;
  localparam int DW = $clog2(DEBOUNCE) + 1;
  localparam int WW = $clog2(WAIT_TICKS) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;

  // Counters compare against "last" values so they stop before ever wrapping.
  localparam logic [HW-1:0] HEAT_LAST  = HW'(HEAT_TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_TICKS - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  function automatic logic fault_of(input logic [SEN_W-1:0] value,
                                    input logic [SEN_W-1:0] ref_value,
                                    input logic [SEN_W-1:0] limit);
    logic [SEN_W-1:0] diff;
    if (value >= ref_value) begin
      diff = value - ref_value;
    end else begin
      diff = ref_value - value;
    end
    return diff > limit;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t          state_r;
    logic [HW-1:0]   heat_cnt_r;
    logic [DW-1:0]   deb_cnt_r;
    logic [WW-1:0]   wait_cnt_r;
    logic [RW-1:0]   retry_cnt_r;
    logic            relay_r;
    logic            fail_r;
    logic            fault_s;

    assign fault_s = fault_of(sen[i*SEN_W +: SEN_W],
                              sen_ref[i*SEN_W +: SEN_W],
                              threshold[i*SEN_W +: SEN_W]);

    // Channel FSM; DEF_FAIL is checked before enable so that enable cannot release it.
    always_ff @(posedge clk_16ms or posedge rst) begin
      if (rst) begin
        state_r     <= ST_IDLE;
        heat_cnt_r  <= '0;
        deb_cnt_r   <= '0;
        wait_cnt_r  <= '0;
        retry_cnt_r <= '0;
        relay_r     <= 1'b0;
        fail_r      <= 1'b0;
      end else if (state_r == ST_DEF_FAIL) begin
        if (clear_fail[i]) begin
          state_r     <= ST_IDLE;
          retry_cnt_r <= '0;
          relay_r     <= 1'b0;
          fail_r      <= 1'b0;
        end else begin
          relay_r <= 1'b1;
          fail_r  <= 1'b1;
        end
      end else if (!enable) begin
        state_r     <= ST_IDLE;
        heat_cnt_r  <= '0;
        deb_cnt_r   <= '0;
        wait_cnt_r  <= '0;
        retry_cnt_r <= '0;
        relay_r     <= 1'b0;
        fail_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r    <= ST_HEAT;
            heat_cnt_r <= '0;
            relay_r    <= 1'b0;
          end
          ST_HEAT: begin
            if (heat_cnt_r >= HEAT_LAST) begin
              state_r    <= ST_MONITOR;
              heat_cnt_r <= '0;
              deb_cnt_r  <= '0;
            end else begin
              heat_cnt_r <= heat_cnt_r + HW'(1);
            end
          end
          ST_MONITOR: begin
            if (!fault_s) begin
              deb_cnt_r <= '0;
            end else if (deb_cnt_r >= DEB_LAST) begin
              state_r   <= ST_OPEN;
              deb_cnt_r <= '0;
              relay_r   <= 1'b1;
            end else begin
              deb_cnt_r <= deb_cnt_r + DW'(1);
            end
          end
          ST_OPEN: begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= '0;
            relay_r    <= 1'b1;
          end
          ST_WAIT: begin
            if (wait_cnt_r >= WAIT_LAST) begin
              state_r    <= ST_RECHECK;
              wait_cnt_r <= '0;
            end else begin
              wait_cnt_r <= wait_cnt_r + WW'(1);
            end
          end
          ST_RECHECK: begin
            if (!fault_s) begin
              state_r     <= ST_MONITOR;
              retry_cnt_r <= '0;
              deb_cnt_r   <= '0;
              relay_r     <= 1'b0;
            end else if (retry_cnt_r >= RETRY_LAST) begin
              state_r     <= ST_DEF_FAIL;
              retry_cnt_r <= RW'(MAX_RETRY);
              relay_r     <= 1'b1;
              fail_r      <= 1'b1;
            end else begin
              state_r     <= ST_WAIT;
              retry_cnt_r <= retry_cnt_r + RW'(1);
              wait_cnt_r  <= '0;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            heat_cnt_r  <= '0;
            deb_cnt_r   <= '0;
            wait_cnt_r  <= '0;
            retry_cnt_r <= '0;
            relay_r     <= 1'b0;
            fail_r      <= 1'b0;
          end
        endcase
      end
    end

    assign relay_out[i]        = relay_r;
    assign def_fail[i]         = fail_r;
    assign state_dbg[3*i +: 3] = state_r;
  end

  // Pure OR of registered flags: no input-to-output path, same timing as def_fail.
  assign any_fail = |def_fail;

endmodule

// File: tb/tb_sensor_guard_multi.sv
// Randomised plus directed bench for sensor_guard_multi against a phase/timestamp model.
module tb_sensor_guard_multi;
  localparam int NC = 2, SW = 8, HEAT = 4, DEB = 2, WAITT = 5, MAXR = 3;
  localparam int P_IDLE = 0, P_HEAT = 1, P_MON = 2, P_OPEN = 3, P_WAIT = 4, P_RCHK = 5, P_DEF = 6;

  logic              clk_16ms = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [NC*SW-1:0]  sen = '0, sen_ref = '0, threshold = '0;
  logic [NC-1:0]     clear_fail = '0;
  logic [NC-1:0]     relay_out, def_fail;
  logic              any_fail;
  logic [3*NC-1:0]   state_dbg;

  sensor_guard_multi #(.N_CH(NC), .SEN_W(SW), .HEAT_TICKS(HEAT), .DEBOUNCE(DEB),
                       .WAIT_TICKS(WAITT), .MAX_RETRY(MAXR)) dut (
    .clk_16ms(clk_16ms), .rst(rst), .enable(enable), .sen(sen), .sen_ref(sen_ref),
    .threshold(threshold), .clear_fail(clear_fail), .relay_out(relay_out),
    .def_fail(def_fail), .any_fail(any_fail), .state_dbg(state_dbg));

  always #5 clk_16ms = ~clk_16ms;

  int checks = 0, passed = 0, cyc = 0;
  // Model: current phase, edge count at phase entry, fault streak, failed rechecks.
  int m_ph[NC], m_enter[NC], m_streak[NC], m_retry[NC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic enter_phase(input int c, input int p);
    m_ph[c] = p;
    m_enter[c] = cyc;
    m_streak[c] = 0;
    if (p == P_IDLE) m_retry[c] = 0;
  endtask

  task automatic model_step(input int c);
    int s, r, t, d;
    bit flt;
    s = int'(sen[c*SW +: SW]);
    r = int'(sen_ref[c*SW +: SW]);
    t = int'(threshold[c*SW +: SW]);
    d = (s > r) ? s - r : r - s;
    flt = (d > t);
    if (m_ph[c] == P_DEF) begin
      if (clear_fail[c]) enter_phase(c, P_IDLE);
    end else if (!enable) begin
      enter_phase(c, P_IDLE);
    end else begin
      case (m_ph[c])
        P_IDLE: enter_phase(c, P_HEAT);
        P_HEAT: if (cyc - m_enter[c] == HEAT) enter_phase(c, P_MON);
        P_MON: begin
          m_streak[c] = flt ? m_streak[c] + 1 : 0;
          if (m_streak[c] == DEB) enter_phase(c, P_OPEN);
        end
        P_OPEN: enter_phase(c, P_WAIT);
        P_WAIT: if (cyc - m_enter[c] == WAITT) enter_phase(c, P_RCHK);
        P_RCHK: begin
          if (!flt) begin
            m_retry[c] = 0;
            enter_phase(c, P_MON);
          end else begin
            m_retry[c]++;
            enter_phase(c, (m_retry[c] == MAXR) ? P_DEF : P_WAIT);
          end
        end
        default: enter_phase(c, P_IDLE);
      endcase
    end
  endtask

  task automatic compare_all();
    logic [3*NC-1:0] e_dbg;
    logic [NC-1:0]   e_rel, e_df;
    for (int c = 0; c < NC; c++) begin
      e_dbg[3*c +: 3] = 3'(m_ph[c]);
      e_rel[c] = (m_ph[c] == P_OPEN) || (m_ph[c] == P_WAIT) || (m_ph[c] == P_RCHK) || (m_ph[c] == P_DEF);
      e_df[c]  = (m_ph[c] == P_DEF);
    end
    check("model_state", 32'(state_dbg), 32'(e_dbg));
    check("model_relay", 32'(relay_out), 32'(e_rel));
    check("model_def_fail", 32'(def_fail), 32'(e_df));
    check("model_any_fail", 32'(any_fail), 32'(|e_df));
  endtask

  task automatic tick();
    @(posedge clk_16ms);
    #1;
    cyc++;
    for (int c = 0; c < NC; c++) model_step(c);
    compare_all();
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_ph[c] = P_IDLE; m_enter[c] = cyc; m_streak[c] = 0; m_retry[c] = 0;
    end
  endtask

  // Called right after a tick: asserts rst mid-cycle and checks outputs drop at once.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    check("rst_relay", 32'(relay_out), 32'd0);
    check("rst_def_fail", 32'(def_fail), 32'd0);
    check("rst_any_fail", 32'(any_fail), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic set_ch(input int c, input int s, input int r, input int t);
    sen[c*SW +: SW] = SW'(s);
    sen_ref[c*SW +: SW] = SW'(r);
    threshold[c*SW +: SW] = SW'(t);
  endtask

  initial begin
    int rc, n;
    model_reset();
    set_ch(0, 100, 100, 10);
    set_ch(1, 50, 50, 5);
    enable = 1'b1;
    #2;
    check("init_relay", 32'(relay_out), 32'd0);
    check("init_state", 32'(state_dbg), 32'd0);
    #20 rst = 1'b0;

    // Warm-up: HEAT for exactly 4 ticks, then MONITOR, relays closed.
    tick();
    check("heat_entry", 32'(state_dbg[2:0]), 32'd1);
    repeat (3) tick();
    check("heat_last", 32'(state_dbg[2:0]), 32'd1);
    tick();
    check("monitor_entry", 32'(state_dbg[2:0]), 32'd2);
    check("warm_relay", 32'(relay_out), 32'd0);

    // diff == threshold and a single-tick glitch must not trip.
    set_ch(0, 110, 100, 10);
    repeat (3) tick();
    set_ch(0, 111, 100, 10); tick();
    set_ch(0, 100, 100, 10); tick();
    check("no_trip", 32'(state_dbg[2:0]), 32'd2);
    set_ch(0, 111, 100, 10);
    repeat (2) tick();
    check("open_state", 32'(state_dbg[2:0]), 32'd3);
    check("open_relay", 32'(relay_out), 32'd1);
    tick();
    check("wait_state", 32'(state_dbg[2:0]), 32'd4);

    // Fault clears before the recheck: back to MONITOR, ch1 untouched.
    set_ch(0, 100, 100, 10);
    repeat (5) tick();
    check("recheck_state", 32'(state_dbg[2:0]), 32'd5);
    tick();
    check("recover_dbg", 32'(state_dbg), 32'b010010);
    check("recover_relay", 32'(relay_out), 32'd0);

    // Persistent fault: three rechecks, then latched failure.
    set_ch(0, 50, 100, 10);
    rc = 0; n = 0;
    while (!def_fail[0] && n < 100) begin
      tick(); n++;
      if (state_dbg[2:0] == 3'd5) rc++;
    end
    check("def_fail_bound", 32'(n < 100), 32'd1);
    check("recheck_count", 32'(rc), 32'd3);
    check("def_fail_vec", 32'(def_fail), 32'd1);
    check("def_any_fail", 32'(any_fail), 32'd1);
    check("def_relay", 32'(relay_out), 32'd1);
    enable = 1'b0;
    repeat (3) tick();
    check("def_hold_enable", 32'(state_dbg[2:0]), 32'd6);
    enable = 1'b1;
    clear_fail = 2'b10;
    tick();
    check("clear_wrong_ch", 32'(state_dbg[2:0]), 32'd6);
    clear_fail = 2'b01;
    tick();
    clear_fail = 2'b00;
    check("clear_state", 32'(state_dbg[2:0]), 32'd0);
    check("clear_relay", 32'(relay_out), 32'd0);

    // Reset during WAIT with two failed rechecks wipes retry history.
    n = 0;
    while (!(m_ph[0] == P_WAIT && m_retry[0] == 2) && n < 200) begin
      tick(); n++;
    end
    check("retry2_bound", 32'(n < 200), 32'd1);
    check("retry2_wait", 32'(state_dbg[2:0]), 32'd4);
    do_reset();
    rc = 0; n = 0;
    while (!def_fail[0] && n < 200) begin
      tick(); n++;
      if (state_dbg[2:0] == 3'd5) rc++;
    end
    check("post_rst_bound", 32'(n < 200), 32'd1);
    check("post_rst_rechecks", 32'(rc), 32'd3);

    // Randomised phase: slowly varying per-channel readings, rare enable drops/clears/resets.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          int r;
          r = int'($urandom_range(30, 225));
          set_ch(c, r + int'($urandom_range(0, 40)) - 20, r, int'($urandom_range(0, 15)));
        end
      end
      enable = ($urandom_range(0, 99) != 0);
      clear_fail = NC'($urandom_range(0, 3)) & {NC{($urandom_range(0, 29) == 0)}};
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
